beta_prefetch_buffer: RTL and testbench
=======================================

Name: beta_prefetch_buffer

Overview:
Instruction prefetch buffer that sits between the instruction memory port and the instruction fetch stage.
- Issues sequential word fetches ahead of demand and tracks outstanding in-order responses.
- Stores returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to the fetch stage with a valid/ready handshake.
- A redirect (branch/jump/hazard) flushes buffered and in-flight instructions and restarts fetching at a new address.

Parameters:
DataWidth, 32, width of address and instruction data
Depth, 4, FIFO entries (power of 2, >=2)
MaxOutstanding, 2, maximum accepted-but-unanswered memory requests (1..Depth)
BootAddr, 32'h0000_0000, fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
pf_fetch_en_i  in  1  allow new memory requests
pf_flush_i  in  1  redirect; discard buffered and in-flight instructions
pf_flush_addr_i  in  DataWidth  new fetch address, sampled when pf_flush_i=1
pf_mem_req_o  out  1  memory request
pf_mem_addr_o  out  DataWidth  request address, word-aligned
pf_mem_ready_i  in  1  memory accepts request this cycle (req&ready = issue)
pf_mem_valid_i  in  1  response data valid, in request order
pf_mem_rdata_i  in  DataWidth  response data
pf_out_valid_o  out  1  FIFO head valid
pf_out_instr_o  out  DataWidth  head instruction
pf_out_pc_o  out  DataWidth  head PC
pf_out_ready_i  in  1  fetch stage consumes head (valid&ready = pop)
pf_busy_o  out  1  outstanding requests or discards pending

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - fetch_addr=BootAddr, resp_pc=BootAddr.
  - FIFO empty; outstanding=0; discard=0.
  - All outputs 0, except pf_mem_addr_o=BootAddr.
- Issue:
  - pf_mem_req_o = pf_fetch_en_i & !pf_flush_i & (outstanding < MaxOutstanding) & (count + outstanding - discard < Depth).
  - Credit rule: every non-discarded response is guaranteed a FIFO slot.
  - pf_mem_addr_o = fetch_addr. On issue, fetch_addr += 4, mod 2^DataWidth (wraps silently).
  - Once asserted, req/addr stay stable until ready, unless pf_flush_i or pf_fetch_en_i drops.
- Outstanding counter:
  - +1 on issue, -1 on pf_mem_valid_i; both in one cycle = unchanged.
  - A response with outstanding=0 is a protocol error; the bench asserts on it.
- Response:
  - If discard>0: data dropped, discard -= 1.
  - Else push {rdata, resp_pc} and resp_pc += 4.
  - Latency from pf_mem_valid_i to pf_out_valid_o is 1 cycle when the FIFO is empty; there is no combinational bypass.
- Pop: on valid&ready the head advances. Push and pop in the same cycle leave count unchanged and are legal at full and at empty+1.
- Flush (pf_flush_i=1), single cycle, highest priority:
  - FIFO cleared; a pop in the same cycle is ignored.
  - fetch_addr <= pf_flush_addr_i & ~3; resp_pc <= same value.
  - discard <= outstanding_next. This counts a same-cycle response as consumed, but still counts a same-cycle issue.
  - A response arriving in the flush cycle is dropped.
  - pf_mem_req_o is forced 0 in the flush cycle.
  - Requests resume the next cycle, even while discard>0, because responses stay in order.
- Back-to-back flushes: each recomputes discard from the current outstanding count, with no accumulation error.
- Control FSM:
  - IDLE: fetch_en=0 and outstanding=0.
  - RUN: fetching.
  - DRAIN: discard>0.
  - Transitions:
    - IDLE->RUN when fetch_en=1.
    - RUN->DRAIN on flush with outstanding_next>0.
    - DRAIN->RUN when the last discard is consumed.
    - RUN->IDLE when fetch_en=0 and outstanding reaches 0.
  - pf_busy_o = (outstanding!=0) | (discard!=0), registered.
- Dropping pf_fetch_en_i stops new issues only. In-flight responses are still buffered, and the FIFO still drains.

Decomposition:
- Package beta_pf_pkg:
  - pf_entry_t struct {instr, pc}.
  - pf_state_e enum {PF_IDLE, PF_RUN, PF_DRAIN}.
  - Constant PF_INSTR_BYTES=4.
- Sub-module beta_pf_fifo:
  - Parameterised by Depth and entry type.
  - Ports: push, pop, clear, full, empty, count, head.
  - Pointer width $clog2(Depth); count width $clog2(Depth)+1.
- Top level holds the issue logic, counters and FSM.

Test Plan:
- Reset, fetch_en=1, memory ready always, 1-cycle response latency -> requests at 0x0,0x4,0x8,...; first pf_out_valid_o at response cycle+1 with pc=0x0; consumer always ready gives 1 instr/cycle steady state.
- Consumer stalled (out_ready=0), Depth=4 -> exactly 4 entries buffered (PCs 0x0..0xC); pf_mem_req_o held low afterwards; no overflow; releasing ready drains them in order.
- Flush to 0x100 with 2 requests outstanding -> the next 2 responses are dropped; first output pc=0x100; pf_busy_o high until the discards are consumed.
- Flush in the same cycle as pf_mem_valid_i and pop -> the response is dropped, discard=outstanding-1, FIFO empty next cycle, the pop has no effect.
- Flush to 0x103 -> pf_mem_addr_o=0x100; then fetch_addr near 0xFFFF_FFFC -> wraps to 0x0.
- Async reset asserted mid-burst, between clock edges -> all outputs 0 immediately; after release, fetch restarts at BootAddr with no stale response forwarded.

Source files
------------

// File: rtl/beta_pf_pkg.sv
// Shared types for the instruction prefetch buffer: FIFO entry layout and control states.
// The entry width is fixed here, so the top-level DataWidth must match PF_DATA_W.
package beta_pf_pkg;

  localparam int PF_DATA_W      = 32;
  localparam int PF_INSTR_BYTES = 4;

  typedef struct packed {
    logic [PF_DATA_W-1:0] instr;
    logic [PF_DATA_W-1:0] pc;
  } pf_entry_t;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_RUN,
    PF_DRAIN
  } pf_state_e;

endpackage

// File: rtl/beta_prefetch_buffer_if.sv
// Memory-side and fetch-side signals of the prefetch buffer.
// The slave modport is the buffer's view; the master modport is the surrounding core/memory.
interface beta_prefetch_buffer_if #(
  parameter int DataWidth = 32
);

  logic                 pf_fetch_en_i;
  logic                 pf_flush_i;
  logic [DataWidth-1:0] pf_flush_addr_i;
  logic                 pf_mem_req_o;
  logic [DataWidth-1:0] pf_mem_addr_o;
  logic                 pf_mem_ready_i;
  logic                 pf_mem_valid_i;
  logic [DataWidth-1:0] pf_mem_rdata_i;
  logic                 pf_out_valid_o;
  logic [DataWidth-1:0] pf_out_instr_o;
  logic [DataWidth-1:0] pf_out_pc_o;
  logic                 pf_out_ready_i;
  logic                 pf_busy_o;

  modport slave (
    input  pf_fetch_en_i, pf_flush_i, pf_flush_addr_i,
    input  pf_mem_ready_i, pf_mem_valid_i, pf_mem_rdata_i, pf_out_ready_i,
    output pf_mem_req_o, pf_mem_addr_o,
    output pf_out_valid_o, pf_out_instr_o, pf_out_pc_o, pf_busy_o
  );

  modport master (
    output pf_fetch_en_i, pf_flush_i, pf_flush_addr_i,
    output pf_mem_ready_i, pf_mem_valid_i, pf_mem_rdata_i, pf_out_ready_i,
    input  pf_mem_req_o, pf_mem_addr_o,
    input  pf_out_valid_o, pf_out_instr_o, pf_out_pc_o, pf_busy_o
  );

endinterface

// File: rtl/beta_pf_fifo.sv
// Small synchronous FIFO holding tagged instructions; clear wins over push and pop.
// Depth must be a power of two so the pointers wrap naturally.
module beta_pf_fifo #(
  parameter int  Depth   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count,
  output entry_t                 head
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth) + 1;

  entry_t          mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; readers only look at the head while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches ahead of demand, buffers PC-tagged
// responses, and on a redirect discards everything still buffered or in flight.
module beta_prefetch_buffer
  import beta_pf_pkg::*;
#(
  parameter int                   DataWidth      = 32,
  parameter int                   Depth          = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [DataWidth-1:0] BootAddr       = '0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  beta_prefetch_buffer_if.slave   pf
);

  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int CntW = $clog2(Depth) + 1;

  logic [DataWidth-1:0] fetch_addr_q;
  logic [DataWidth-1:0] resp_pc_q;
  logic [DataWidth-1:0] flush_addr_aligned;
  logic [OutW-1:0]      outstanding_q, outstanding_d;
  logic [OutW-1:0]      discard_q, discard_d;
  logic                 busy_q;
  pf_state_e            state_q, state_d;

  logic                 issue, resp, push, pop, drop_resp;
  logic [31:0]          credit_used;
  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  pf_entry_t            push_entry, head_entry;

  assign flush_addr_aligned = pf.pf_flush_addr_i & ~DataWidth'(PF_INSTR_BYTES - 1);

  // Slots already promised: buffered entries plus responses that will actually be kept.
  assign credit_used = 32'(fifo_count) + 32'(outstanding_q) - 32'(discard_q);

  // Gated by reset so the request line reads 0 the moment reset is asserted.
  assign pf.pf_mem_req_o  = rstn_i & pf.pf_fetch_en_i & ~pf.pf_flush_i
                          & (32'(outstanding_q) < 32'(MaxOutstanding))
                          & (credit_used < 32'(Depth));
  assign pf.pf_mem_addr_o = fetch_addr_q;

  assign issue = pf.pf_mem_req_o & pf.pf_mem_ready_i;
  assign resp  = pf.pf_mem_valid_i;
  assign push  = resp & ~drop_resp & ~pf.pf_flush_i & ~fifo_full;
  assign pop   = ~fifo_empty & pf.pf_out_ready_i & ~pf.pf_flush_i;

  assign push_entry = '{instr: pf.pf_mem_rdata_i, pc: resp_pc_q};

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !resp)      outstanding_d = outstanding_q + OutW'(1);
    else if (!issue && resp) outstanding_d = outstanding_q - OutW'(1);
  end

  // A flush re-derives the discard count from scratch, which keeps back-to-back flushes exact.
  always_comb begin
    discard_d = discard_q;
    if (pf.pf_flush_i)           discard_d = outstanding_d;
    else if (resp && drop_resp)  discard_d = discard_q - OutW'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= PF_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PF_IDLE:  if (pf.pf_fetch_en_i) state_d = PF_RUN;
      PF_RUN: begin
        if (discard_d != '0)                                state_d = PF_DRAIN;
        else if (!pf.pf_fetch_en_i && outstanding_d == '0) state_d = PF_IDLE;
      end
      PF_DRAIN: if (discard_d == '0) state_d = PF_RUN;
      default:  state_d = PF_IDLE;
    endcase
  end

  always_comb begin
    drop_resp = (state_q == PF_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_addr_q  <= BootAddr;
      resp_pc_q     <= BootAddr;
      outstanding_q <= '0;
      discard_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      busy_q        <= (outstanding_d != '0) | (discard_d != '0);
      if (pf.pf_flush_i) begin
        fetch_addr_q <= flush_addr_aligned;
        resp_pc_q    <= flush_addr_aligned;
      end else begin
        if (issue) fetch_addr_q <= fetch_addr_q + DataWidth'(PF_INSTR_BYTES);
        if (push)  resp_pc_q    <= resp_pc_q + DataWidth'(PF_INSTR_BYTES);
      end
    end
  end

  beta_pf_fifo #(
    .Depth   (Depth),
    .entry_t (pf_entry_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .pop    (pop),
    .clear  (pf.pf_flush_i),
    .din    (push_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .head   (head_entry)
  );

  assign pf.pf_out_valid_o = ~fifo_empty;
  assign pf.pf_out_instr_o = fifo_empty ? '0 : head_entry.instr;
  assign pf.pf_out_pc_o    = fifo_empty ? '0 : head_entry.pc;
  assign pf.pf_busy_o      = busy_q;

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Bench for beta_prefetch_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the in-order memory and the instruction stream.
module tb_beta_prefetch_buffer;
  import beta_pf_pkg::*;

  localparam int Depth  = 4;
  localparam int MaxOut = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  beta_prefetch_buffer_if #(.DataWidth(32)) pf_bus ();

  beta_prefetch_buffer #(
    .DataWidth      (32),
    .Depth          (Depth),
    .MaxOutstanding (MaxOut),
    .BootAddr       (32'h0000_0000)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .pf     (pf_bus)
  );

  typedef struct { logic [31:0] addr; bit stale; int cyc; } flight_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;

  flight_t     inflight[$];
  item_t       model_fifo[$];
  logic [31:0] model_fetch_addr = 32'h0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          p_valid = 100;

  logic        cap_req, cap_valid, cap_busy;
  logic [31:0] cap_addr, cap_pc, cap_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input logic exp_req);
    checkValue("mem_req", 32'(pf_bus.pf_mem_req_o), 32'(exp_req));
    if (exp_req) checkValue("mem_addr", pf_bus.pf_mem_addr_o, model_fetch_addr);
    checkValue("out_valid", 32'(pf_bus.pf_out_valid_o), 32'(model_fifo.size() != 0));
    if (model_fifo.size() != 0) begin
      checkValue("out_pc", pf_bus.pf_out_pc_o, model_fifo[0].pc);
      checkValue("out_instr", pf_bus.pf_out_instr_o, model_fifo[0].instr);
    end
    checkValue("busy", 32'(pf_bus.pf_busy_o), 32'(inflight.size() != 0));
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model past the next rising edge.
  task automatic applyStimulus(input logic fetch_en, input logic flush, input logic [31:0] faddr,
                               input logic mready, input logic oready);
    int      live;
    logic    mvalid, exp_req, issue;
    flight_t r;
    @(negedge clk);
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    mvalid = (inflight.size() > 0) && (inflight[0].cyc < cyc) && ($urandom_range(99) < p_valid);
    pf_bus.pf_fetch_en_i   = fetch_en;
    pf_bus.pf_flush_i      = flush;
    pf_bus.pf_flush_addr_i = faddr;
    pf_bus.pf_mem_ready_i  = mready;
    pf_bus.pf_out_ready_i  = oready;
    pf_bus.pf_mem_valid_i  = mvalid;
    pf_bus.pf_mem_rdata_i  = mvalid ? mem_word(inflight[0].addr) : $urandom();
    #1;
    exp_req = fetch_en && !flush && (inflight.size() < MaxOut) && (model_fifo.size() + live < Depth);
    checkOutput(exp_req);
    cap_req   = pf_bus.pf_mem_req_o;
    cap_addr  = pf_bus.pf_mem_addr_o;
    cap_valid = pf_bus.pf_out_valid_o;
    cap_pc    = pf_bus.pf_out_pc_o;
    cap_instr = pf_bus.pf_out_instr_o;
    cap_busy  = pf_bus.pf_busy_o;

    issue = exp_req && mready;
    if (!flush && oready && model_fifo.size() > 0) void'(model_fifo.pop_front());
    if (mvalid) begin
      r = inflight.pop_front();
      if (!flush && !r.stale) model_fifo.push_back('{instr: mem_word(r.addr), pc: r.addr});
    end
    if (issue) begin
      inflight.push_back('{addr: model_fetch_addr, stale: 1'b0, cyc: cyc});
      model_fetch_addr = model_fetch_addr + 32'd4;
    end
    if (flush) begin
      model_fifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      model_fetch_addr = faddr & ~32'h3;
    end
    cyc++;
  endtask

  task automatic idleInputs();
    pf_bus.pf_fetch_en_i   = 1'b0;
    pf_bus.pf_flush_i      = 1'b0;
    pf_bus.pf_flush_addr_i = 32'h0;
    pf_bus.pf_mem_ready_i  = 1'b0;
    pf_bus.pf_out_ready_i  = 1'b0;
    pf_bus.pf_mem_valid_i  = 1'b0;
    pf_bus.pf_mem_rdata_i  = 32'h0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, "_req"},   32'(pf_bus.pf_mem_req_o), 32'd0);
    checkValue({tag, "_addr"},  pf_bus.pf_mem_addr_o, 32'h0);
    checkValue({tag, "_valid"}, 32'(pf_bus.pf_out_valid_o), 32'd0);
    checkValue({tag, "_instr"}, pf_bus.pf_out_instr_o, 32'h0);
    checkValue({tag, "_pc"},    pf_bus.pf_out_pc_o, 32'h0);
    checkValue({tag, "_busy"},  32'(pf_bus.pf_busy_o), 32'd0);
  endtask

  // Reset lands between clock edges while the previous cycle's inputs are still applied.
  task automatic asyncReset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    inflight.delete();
    model_fifo.delete();
    model_fetch_addr = 32'h0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int req_seen;
    logic [31:0] faddr;

    idleInputs();
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Steady streaming: one instruction per cycle, first one two cycles after the first request.
    p_valid = 100;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) begin
        checkValue("first_req", 32'(cap_req), 32'd1);
        checkValue("first_addr", cap_addr, 32'h0);
      end
      if (i == 1) checkValue("no_bypass", 32'(cap_valid), 32'd0);
      if (i >= 2) begin
        checkValue("steady_valid", 32'(cap_valid), 32'd1);
        checkValue("steady_pc", cap_pc, 32'(4 * (i - 2)));
      end
    end

    // Stalled consumer fills exactly Depth entries, then drains in order.
    asyncReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkValue("stall_req", 32'(cap_req), 32'd0);
    checkValue("stall_head", cap_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkValue("drain_pc", cap_pc, 32'(4 * i));
    end

    // Flush with two requests outstanding: both responses dropped, stream restarts at 0x100.
    p_valid = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
    p_valid = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) begin
        checkValue("flush_busy", 32'(cap_busy), 32'd1);
        checkValue("flush_addr", cap_addr, 32'h100);
      end
      if (cap_valid) begin
        found = 1'b1;
        checkValue("flush_first_pc", cap_pc, 32'h100);
      end
    end
    checkValue("flush_first_seen", 32'(found), 32'd1);

    // Flush coinciding with a response and a pop.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkValue("flush_pop_valid", 32'(cap_valid), 32'd0);
    checkValue("flush_pop_busy", 32'(cap_busy), 32'd0);
    checkValue("flush_pop_addr", cap_addr, 32'h200);

    // Unaligned redirect, then address wrap at the top of the space.
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkValue("align_addr", cap_addr, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    req_seen = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      if (req_seen < 0 && cap_req) begin
        req_seen = i;
        checkValue("wrap_last", cap_addr, 32'hFFFF_FFFC);
      end else if (req_seen >= 0 && i == req_seen + 1) begin
        checkValue("wrap_zero", cap_addr, 32'h0);
      end
    end
    checkValue("wrap_issued", 32'(req_seen >= 0), 32'd1);

    // Randomized traffic with a mid-burst asynchronous reset.
    p_valid = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        asyncReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        checkValue("restart_req", 32'(cap_req), 32'd1);
        checkValue("restart_addr", cap_addr, 32'h0);
      end
      faddr = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      applyStimulus(($urandom_range(7) != 0), ($urandom_range(15) == 0), faddr,
                    ($urandom_range(2) != 0), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
